// File: rtl/cache_bus_pkg.sv
// Shared definitions for the 64-byte line protocol between the L1 arbiter and memory-side responders.
package cache_bus_pkg;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam int LINE_BEATS       = 8;
   localparam int LINE_OFFSET_BITS = 6;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_BEAT,
      WR_GAP,
      WR_DATA,
      WR_COMMIT
   } resp_state_t;

endpackage

// File: rtl/line_store.sv
// Line-wide backing store: combinational read of the indexed line, full-line synchronous write.
module line_store
   import cache_bus_pkg::*;
#(
   parameter int WORDSIZE = 64,
   parameter int LOGLINES = 10
) (
   input  logic                           clk,
   input  logic [LOGLINES-1:0]            index,
   input  logic                           wr_en,
   input  logic [LINE_BEATS*WORDSIZE-1:0] wr_line,
   output logic [LINE_BEATS*WORDSIZE-1:0] rd_line
);

   // Contents are deliberately not reset; the store survives responder resets.
   logic [LINE_BEATS*WORDSIZE-1:0] mem [2**LOGLINES];

   always_ff @(posedge clk) begin
      if (wr_en) mem[index] <= wr_line;
   end

   assign rd_line = mem[index];

endmodule

// File: rtl/line_memory_responder.sv
// Memory-side responder for the 64-byte line protocol: 8-beat read bursts, address+8-beat write bursts.
module line_memory_responder
   import cache_bus_pkg::*;
#(
   parameter int WORDSIZE     = 64,
   parameter int LOGLINES     = 10,
   parameter int READ_LATENCY = 4,
   parameter int TAGWIDTH     = 13
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reqcyc,
   output logic                reqack,
   input  logic [WORDSIZE-1:0] req,
   input  logic [TAGWIDTH-1:0] reqtag,
   output logic                respcyc,
   input  logic                respack,
   output logic [WORDSIZE-1:0] resp,
   output logic [TAGWIDTH-1:0] resptag,
   output logic                writeack
);

   localparam int LATW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int LINEW = LINE_BEATS * WORDSIZE;

   resp_state_t         state;
   logic [LOGLINES-1:0] idx;
   logic [TAGWIDTH-1:0] tag_q;
   logic [2:0]          beat;
   logic [LATW-1:0]     lat;
   logic [WORDSIZE-1:0] wbuf [LINE_BEATS];
   logic [WORDSIZE-1:0] rd_beats [LINE_BEATS];
   logic [LINEW-1:0]    rd_line;
   logic [LINEW-1:0]    wr_line;
   logic                commit;
   logic                unused_req_bits;

   assign commit          = (state == WR_COMMIT);
   assign unused_req_bits = ^{req[LINE_OFFSET_BITS-1:0], req[WORDSIZE-1:LINE_OFFSET_BITS+LOGLINES]};

   for (genvar g = 0; g < LINE_BEATS; g++) begin : g_beats
      assign wr_line[g*WORDSIZE +: WORDSIZE] = wbuf[g];
      assign rd_beats[g]                     = rd_line[g*WORDSIZE +: WORDSIZE];
   end

   line_store #(
      .WORDSIZE(WORDSIZE),
      .LOGLINES(LOGLINES)
   ) u_store (
      .clk    (clk),
      .index  (idx),
      .wr_en  (commit),
      .wr_line(wr_line),
      .rd_line(rd_line)
   );

   // Write buffer is not reset: a reset mid-write simply never reaches WR_COMMIT.
   always_ff @(posedge clk) begin
      if (state == WR_DATA && reqcyc) wbuf[beat] <= req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         tag_q    <= '0;
         beat     <= '0;
         lat      <= '0;
         reqack   <= 1'b0;
         respcyc  <= 1'b0;
         resp     <= '0;
         resptag  <= '0;
         writeack <= 1'b0;
      end else begin
         reqack   <= 1'b0;
         writeack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (reqcyc) begin
                  reqack <= 1'b1;
                  idx    <= req[LINE_OFFSET_BITS +: LOGLINES];
                  tag_q  <= reqtag;
                  beat   <= '0;
                  if (reqtag[TAGWIDTH-1] == READ) begin
                     lat   <= LATW'(READ_LATENCY - 1);
                     state <= RD_WAIT;
                  end else begin
                     state <= WR_GAP;
                  end
               end
            end
            RD_WAIT: begin
               if (lat == '0) begin
                  respcyc <= 1'b1;
                  resp    <= rd_beats[0];
                  resptag <= tag_q;
                  state   <= RD_BEAT;
               end else begin
                  lat <= lat - 1'b1;
               end
            end
            // respcyc is always high here, so respack alone completes a beat.
            RD_BEAT: begin
               if (respack) begin
                  if (beat == 3'd7) begin
                     respcyc <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     beat <= beat + 3'd1;
                     resp <= rd_beats[beat + 3'd1];
                  end
               end
            end
            WR_GAP: state <= WR_DATA;
            WR_DATA: begin
               if (reqcyc) begin
                  reqack <= 1'b1;
                  if (beat == 3'd7) begin
                     writeack <= 1'b1;
                     state    <= WR_COMMIT;
                  end else begin
                     beat  <= beat + 3'd1;
                     state <= WR_GAP;
                  end
               end
            end
            WR_COMMIT: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule
